vx_axi_mem_slave: RTL and testbench

// - AXI4 memory responder for one bank: the far end of the AFU's m_axi_mem_* master ports.
// - Accepts AW/W/AR bursts, stores data in on-chip RAM, returns B and R responses.
// - Used as the bank model in AFU simulation and in standalone FPGA bring-up builds.

---
 rtl/vx_axi_mem_pkg.sv | 23 ++
 rtl/vx_axi_mem_ram.sv | 35 +++
 rtl/vx_axi_mem_slave.sv | 230 +++++++++++++++++++++++
 tb/tb_vx_axi_mem_slave.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_axi_mem_pkg.sv
// Shared response codes, FSM state encodings and the FSM debug view for vx_axi_mem_slave.
package vx_axi_mem_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_BURST = 1'b1
    } rd_state_e;

    typedef struct packed {
        wr_state_e wr_state;
        rd_state_e rd_state;
    } fsm_dbg_t;

endpackage

// File: rtl/vx_axi_mem_ram.sv
// Simple dual-port bank RAM: byte-enable write port, registered read port, no reset.
module vx_axi_mem_ram #(
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH_LOG2 = 14
) (
    input  logic                    clk_i,
    input  logic                    we_i,
    input  logic [DEPTH_LOG2-1:0]   waddr_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic                    re_i,
    input  logic [DEPTH_LOG2-1:0]   raddr_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Read and write share one block so a same-address collision returns the old word.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
        if (we_i) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/vx_axi_mem_slave.sv
// AXI4 single-bank memory responder: write FSM, read FSM, inflight tracking and a 2-entry R FIFO.
// Define VX_AXI_MEM_OOR_SLVERR_EN to fault out-of-range beats with SLVERR instead of wrapping the index.
module vx_axi_mem_slave
    import vx_axi_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH   = 32,
    parameter int DEPTH_LOG2 = 14
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [7:0]              awlen,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [7:0]              arlen,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [1:0]              rresp,
    output logic                    rlast
);

    localparam int OFF  = $clog2(DATA_WIDTH/8);
    localparam int IDXW = ADDR_WIDTH - OFF;
    localparam logic [IDXW-1:0] IDX_ONE = IDXW'(1);

    // Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
    wr_state_e             wr_state_q, wr_state_d;
    logic [ID_WIDTH-1:0]   aw_id_q, aw_id_d;
    logic [7:0]            aw_len_q, aw_len_d, w_beat_q, w_beat_d;
    logic [IDXW-1:0]       w_idx_q, w_idx_d;
    logic                  w_err_q, w_err_d;
    logic                  w_fire, w_last_beat, w_oor;

    rd_state_e             rd_state_q, rd_state_d;
    logic [ID_WIDTH-1:0]   ar_id_q, ar_id_d;
    logic [7:0]            ar_len_q, ar_len_d, r_beat_q, r_beat_d;
    logic [IDXW-1:0]       r_idx_q, r_idx_d;
    logic                  r_last_beat, r_oor, issue, pop;

    logic                  inflight_q, pipe_last_q, pipe_oor_q;
    logic [ID_WIDTH-1:0]   pipe_id_q;
    logic [DATA_WIDTH-1:0] ram_rdata;

    logic [DATA_WIDTH-1:0] fifo_data_q [2];
    logic [ID_WIDTH-1:0]   fifo_id_q [2];
    logic [1:0]            fifo_resp_q [2];
    logic                  fifo_last_q [2];
    logic                  fifo_wptr_q, fifo_rptr_q;
    logic [1:0]            fifo_cnt_q, fifo_cnt_d;

    fsm_dbg_t              fsm_dbg;
    logic                  unused_ok;

`ifdef VX_AXI_MEM_OOR_SLVERR_EN
    assign w_oor = |w_idx_q[IDXW-1:DEPTH_LOG2];
    assign r_oor = |r_idx_q[IDXW-1:DEPTH_LOG2];
`else
    assign w_oor = 1'b0;
    assign r_oor = 1'b0;
`endif

    assign awready     = (wr_state_q == W_IDLE);
    assign wready      = (wr_state_q == W_DATA);
    assign bvalid      = (wr_state_q == W_RESP);
    assign bid         = aw_id_q;
    assign bresp       = (bvalid && w_err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    assign w_fire      = wvalid && wready;
    assign w_last_beat = (w_beat_q == aw_len_q);

    always_comb begin
        wr_state_d = wr_state_q;
        aw_id_d    = aw_id_q;
        aw_len_d   = aw_len_q;
        w_beat_d   = w_beat_q;
        w_idx_d    = w_idx_q;
        w_err_d    = w_err_q;
        case (wr_state_q)
            W_IDLE: if (awvalid) begin
                aw_id_d    = awid;
                aw_len_d   = awlen;
                w_idx_d    = awaddr[ADDR_WIDTH-1:OFF];
                w_beat_d   = '0;
                w_err_d    = 1'b0;
                wr_state_d = W_DATA;
            end
            W_DATA: if (wvalid) begin
                // Beat count alone ends the burst; wlast only feeds the error flag.
                w_err_d = w_err_q | (wlast != w_last_beat) | w_oor;
                if (w_last_beat) begin
                    wr_state_d = W_RESP;
                end else begin
                    w_beat_d = w_beat_q + 8'd1;
                    w_idx_d  = w_idx_q + IDX_ONE;
                end
            end
            W_RESP: if (bready) wr_state_d = W_IDLE;
            default: wr_state_d = W_IDLE;
        endcase
    end

    assign arready     = (rd_state_q == R_IDLE);
    assign r_last_beat = (r_beat_q == ar_len_q);
    assign pop         = rvalid && rready;
    // Next FIFO occupancy; a new read may issue only if its data will still find a free slot.
    assign fifo_cnt_d  = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    assign issue       = (rd_state_q == R_BURST) && (fifo_cnt_d < 2'd2);

    always_comb begin
        rd_state_d = rd_state_q;
        ar_id_d    = ar_id_q;
        ar_len_d   = ar_len_q;
        r_beat_d   = r_beat_q;
        r_idx_d    = r_idx_q;
        case (rd_state_q)
            R_IDLE: if (arvalid) begin
                ar_id_d    = arid;
                ar_len_d   = arlen;
                r_idx_d    = araddr[ADDR_WIDTH-1:OFF];
                r_beat_d   = '0;
                rd_state_d = R_BURST;
            end
            R_BURST: if (issue) begin
                if (r_last_beat) begin
                    rd_state_d = R_IDLE;
                end else begin
                    r_beat_d = r_beat_q + 8'd1;
                    r_idx_d  = r_idx_q + IDX_ONE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_state_q  <= W_IDLE;
            aw_id_q     <= '0;
            aw_len_q    <= '0;
            w_beat_q    <= '0;
            w_idx_q     <= '0;
            w_err_q     <= 1'b0;
            rd_state_q  <= R_IDLE;
            ar_id_q     <= '0;
            ar_len_q    <= '0;
            r_beat_q    <= '0;
            r_idx_q     <= '0;
            inflight_q  <= 1'b0;
            pipe_id_q   <= '0;
            pipe_last_q <= 1'b0;
            pipe_oor_q  <= 1'b0;
            fifo_wptr_q <= 1'b0;
            fifo_rptr_q <= 1'b0;
            fifo_cnt_q  <= '0;
        end else begin
            wr_state_q  <= wr_state_d;
            aw_id_q     <= aw_id_d;
            aw_len_q    <= aw_len_d;
            w_beat_q    <= w_beat_d;
            w_idx_q     <= w_idx_d;
            w_err_q     <= w_err_d;
            rd_state_q  <= rd_state_d;
            ar_id_q     <= ar_id_d;
            ar_len_q    <= ar_len_d;
            r_beat_q    <= r_beat_d;
            r_idx_q     <= r_idx_d;
            inflight_q  <= issue;
            if (issue) begin
                pipe_id_q   <= ar_id_q;
                pipe_last_q <= r_last_beat;
                pipe_oor_q  <= r_oor;
            end
            if (inflight_q) fifo_wptr_q <= ~fifo_wptr_q;
            if (pop)        fifo_rptr_q <= ~fifo_rptr_q;
            fifo_cnt_q  <= fifo_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (inflight_q) begin
            fifo_data_q[fifo_wptr_q] <= pipe_oor_q ? '0 : ram_rdata;
            fifo_id_q[fifo_wptr_q]   <= pipe_id_q;
            fifo_resp_q[fifo_wptr_q] <= pipe_oor_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            fifo_last_q[fifo_wptr_q] <= pipe_last_q;
        end
    end

    assign rvalid = (fifo_cnt_q != 2'd0);
    assign rdata  = fifo_data_q[fifo_rptr_q];
    assign rid    = rvalid ? fifo_id_q[fifo_rptr_q] : '0;
    assign rresp  = rvalid ? fifo_resp_q[fifo_rptr_q] : AXI_RESP_OKAY;
    assign rlast  = rvalid && fifo_last_q[fifo_rptr_q];

    vx_axi_mem_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (w_fire && !w_oor),
        .waddr_i (w_idx_q[DEPTH_LOG2-1:0]),
        .wstrb_i (wstrb),
        .wdata_i (wdata),
        .re_i    (issue),
        .raddr_i (r_idx_q[DEPTH_LOG2-1:0]),
        .rdata_o (ram_rdata)
    );

    // FSM view for probes; low address bits and wrapped index bits are intentionally dropped.
    assign fsm_dbg   = '{wr_state: wr_state_q, rd_state: rd_state_q};
    assign unused_ok = ^{fsm_dbg, awaddr[OFF-1:0], araddr[OFF-1:0],
                         w_idx_q[IDXW-1:DEPTH_LOG2], r_idx_q[IDXW-1:DEPTH_LOG2]};

endmodule

// File: tb/tb_vx_axi_mem_slave.sv
// Directed self-checking bench for vx_axi_mem_slave; honours VX_AXI_MEM_OOR_SLVERR_EN when defined.
module tb_vx_axi_mem_slave;

    localparam int DW = 512;
    localparam int SW = DW/8;
    localparam int AW = 64;
    localparam int IW = 32;
    localparam int DL = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          awvalid = 1'b0, awready;
    logic [AW-1:0] awaddr = '0;
    logic [IW-1:0] awid = '0;
    logic [7:0]    awlen = '0;
    logic          wvalid = 1'b0, wready;
    logic [DW-1:0] wdata = '0;
    logic [SW-1:0] wstrb = '0;
    logic          wlast = 1'b0;
    logic          bvalid, bready = 1'b0;
    logic [IW-1:0] bid;
    logic [1:0]    bresp;
    logic          arvalid = 1'b0, arready;
    logic [AW-1:0] araddr = '0;
    logic [IW-1:0] arid = '0;
    logic [7:0]    arlen = '0;
    logic          rvalid, rready = 1'b0;
    logic [DW-1:0] rdata;
    logic [IW-1:0] rid;
    logic [1:0]    rresp;
    logic          rlast;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_data_q[$];
    logic          got_last_q[$];
    logic [1:0]    got_resp_q[$];
    logic [IW-1:0] got_id_q[$];
    int            got_cyc_q[$];
    int            first_valid_cyc;
    int            extra_beats;

    vx_axi_mem_slave #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .ID_WIDTH   (IW),
        .DEPTH_LOG2 (DL)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] burst_word(input int i);
        return {16{32'hC0DE0000 + 32'(i)}};
    endfunction

    // ---------------- driver tasks (all return #1 after the handshake edge)
    task automatic do_aw(input logic [AW-1:0] addr, input logic [7:0] len, input logic [IW-1:0] id);
        int n = 0;
        awaddr = addr; awlen = len; awid = id; awvalid = 1'b1;
        while (!awready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        awvalid = 1'b0;
        checks++;
        if (n >= 50) begin failures++; $display("FAIL aw_handshake: awready never seen within %0d cycles", n); end
    endtask

    task automatic do_w_beat(input logic [DW-1:0] data, input logic [SW-1:0] strb, input logic last);
        int n = 0;
        wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
        while (!wready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        wvalid = 1'b0; wlast = 1'b0;
        checks++;
        if (n >= 50) begin failures++; $display("FAIL w_handshake: wready never seen within %0d cycles", n); end
    endtask

    task automatic wait_b(output logic [IW-1:0] id, output logic [1:0] resp);
        int n = 0;
        while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
        id = bid; resp = bresp;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        checks++;
        if (n >= 50) begin failures++; $display("FAIL b_handshake: bvalid never seen within %0d cycles", n); end
    endtask

    task automatic do_ar(input logic [AW-1:0] addr, input logic [7:0] len, input logic [IW-1:0] id);
        int n = 0;
        araddr = addr; arlen = len; arid = id; arvalid = 1'b1;
        while (!arready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        arvalid = 1'b0;
        checks++;
        if (n >= 50) begin failures++; $display("FAIL ar_handshake: arready never seen within %0d cycles", n); end
    endtask

    // Issues a read and collects beats; cycle 0 is the cycle right after the AR handshake.
    task automatic do_read(input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [IW-1:0] id, input logic backpressure);
        int cyc = 0;
        got_data_q.delete(); got_last_q.delete(); got_resp_q.delete();
        got_id_q.delete(); got_cyc_q.delete();
        first_valid_cyc = -1;
        extra_beats = 0;
        do_ar(addr, len, id);
        while (got_data_q.size() < int'(len) + 1 && cyc < 300) begin
            rready = backpressure ? cyc[0] : 1'b1;
            if (rvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (rvalid && rready) begin
                got_data_q.push_back(rdata); got_last_q.push_back(rlast);
                got_resp_q.push_back(rresp); got_id_q.push_back(rid);
                got_cyc_q.push_back(cyc);
            end
            @(posedge clk); #1;
            cyc++;
        end
        rready = 1'b1;
        repeat (4) begin
            if (rvalid) extra_beats++;
            @(posedge clk); #1;
        end
        rready = 1'b0;
    endtask

    task automatic write_single(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                input logic [SW-1:0] strb, output logic [1:0] resp);
        logic [IW-1:0] id;
        do_aw(addr, 8'd0, 32'd1);
        do_w_beat(data, strb, 1'b1);
        wait_b(id, resp);
    endtask

    // ---------------- scenarios
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (awready !== 1'b1) begin failures++; $display("FAIL reset_awready: got %b exp 1", awready); end
        checks++; if (arready !== 1'b1) begin failures++; $display("FAIL reset_arready: got %b exp 1", arready); end
        checks++; if ({wready, bvalid, rvalid, rlast} !== 4'b0) begin
            failures++; $display("FAIL reset_valids: wready/bvalid/rvalid/rlast got %b exp 0000", {wready, bvalid, rvalid, rlast});
        end
        checks++; if ({bresp, rresp} !== 4'b0 || bid !== '0 || rid !== '0) begin
            failures++; $display("FAIL reset_resp_id: bresp %0d rresp %0d bid %0h rid %0h exp all 0", bresp, rresp, bid, rid);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (awready !== 1'b1 || arready !== 1'b1) begin
            failures++; $display("FAIL post_reset_ready: awready %b arready %b exp 1 1", awready, arready);
        end
    endtask

    task automatic test_single_write();
        logic [IW-1:0] id;
        logic [1:0]    resp;
        do_aw(64'h40, 8'd0, 32'd5);
        do_w_beat({SW{8'hA5}}, {SW{1'b1}}, 1'b1);
        checks++; if (bvalid !== 1'b1) begin failures++; $display("FAIL single_b_latency: bvalid got %b exp 1 one cycle after W", bvalid); end
        wait_b(id, resp);
        checks++; if (id !== 32'd5) begin failures++; $display("FAIL single_bid: got %0d exp 5", id); end
        checks++; if (resp !== 2'd0) begin failures++; $display("FAIL single_bresp: got %0d exp 0", resp); end
        checks++; if (bvalid !== 1'b0 || awready !== 1'b1) begin
            failures++; $display("FAIL single_after_b: bvalid %b awready %b exp 0 1", bvalid, awready);
        end
    endtask

    task automatic test_readback();
        do_read(64'h40, 8'd0, 32'd7, 1'b0);
        checks++; if (first_valid_cyc !== 2) begin failures++; $display("FAIL readback_latency: got %0d exp 2", first_valid_cyc); end
        checks++;
        if (got_data_q.size() != 1) begin
            failures++; $display("FAIL readback_count: got %0d exp 1", got_data_q.size());
        end else if (got_data_q[0] !== {SW{8'hA5}} || got_id_q[0] !== 32'd7 || got_last_q[0] !== 1'b1 || got_resp_q[0] !== 2'd0) begin
            failures++;
            $display("FAIL readback_beat: data %0h id %0d last %b resp %0d exp a5.. 7 1 0",
                     got_data_q[0], got_id_q[0], got_last_q[0], got_resp_q[0]);
        end
    endtask

    task automatic test_burst_backpressure();
        logic [IW-1:0] id;
        logic [1:0]    resp;
        do_aw(64'h400, 8'd15, 32'd8);
        for (int i = 0; i < 16; i++) do_w_beat(burst_word(i), {SW{1'b1}}, i == 15);
        wait_b(id, resp);
        checks++; if (resp !== 2'd0 || id !== 32'd8) begin failures++; $display("FAIL burst_b: resp %0d id %0d exp 0 8", resp, id); end

        for (int i = 0; i < 16; i++) exp_q.push_back(burst_word(i));
        do_read(64'h400, 8'd15, 32'd9, 1'b1);
        checks++; if (got_data_q.size() != 16) begin failures++; $display("FAIL burst_bp_count: got %0d exp 16", got_data_q.size()); end
        checks++; if (extra_beats != 0) begin failures++; $display("FAIL burst_bp_extra: got %0d extra beats exp 0", extra_beats); end
        for (int i = 0; i < got_data_q.size(); i++) begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            checks++;
            if (got_data_q[i] !== e || got_last_q[i] !== (i == 15) || got_id_q[i] !== 32'd9 || got_resp_q[i] !== 2'd0) begin
                failures++;
                $display("FAIL burst_bp_beat%0d: data %0h last %b id %0d resp %0d exp %0h %b 9 0",
                         i, got_data_q[i], got_last_q[i], got_id_q[i], got_resp_q[i], e, i == 15);
            end
        end
        exp_q.delete();

        // Same burst at full rate: one beat per cycle starting two cycles after AR.
        do_read(64'h400, 8'd15, 32'd10, 1'b0);
        checks++; if (got_data_q.size() != 16) begin failures++; $display("FAIL burst_full_count: got %0d exp 16", got_data_q.size()); end
        for (int i = 0; i < got_data_q.size(); i++) begin
            checks++;
            if (got_cyc_q[i] != 2 + i || got_data_q[i] !== burst_word(i)) begin
                failures++; $display("FAIL burst_full_beat%0d: cycle %0d data %0h exp cycle %0d data %0h",
                                     i, got_cyc_q[i], got_data_q[i], 2 + i, burst_word(i));
            end
        end
    endtask

    task automatic test_partial_strobe();
        logic [1:0]    resp;
        logic [DW-1:0] e;
        e = {{(DW-8){1'b1}}, 8'h00};
        write_single(64'h800, {DW{1'b1}}, {SW{1'b1}}, resp);
        write_single(64'h800, {DW{1'b0}}, 64'h1, resp);
        do_read(64'h800, 8'd0, 32'd1, 1'b0);
        checks++;
        if (got_data_q.size() != 1 || got_data_q[0] !== e) begin
            failures++; $display("FAIL partial_strobe: got %0h exp %0h (beats %0d)",
                                 got_data_q.size() ? got_data_q[0] : '0, e, got_data_q.size());
        end
    endtask

    task automatic test_wlast_early();
        logic [IW-1:0] id;
        logic [1:0]    resp;
        do_aw(64'hC00, 8'd3, 32'd12);
        for (int i = 0; i < 4; i++) begin
            do_w_beat(burst_word(100 + i), {SW{1'b1}}, i == 2);
            checks++;
            if (bvalid !== (i == 3) || wready !== (i != 3)) begin
                failures++; $display("FAIL wlast_early_beat%0d: bvalid %b wready %b exp %b %b", i, bvalid, wready, i == 3, i != 3);
            end
        end
        wait_b(id, resp);
        checks++; if (resp !== 2'd2 || id !== 32'd12) begin failures++; $display("FAIL wlast_early_b: resp %0d id %0d exp 2 12", resp, id); end
    endtask

    task automatic test_out_of_range();
        logic [1:0]    resp;
        logic [DW-1:0] e_data;
        logic [1:0]    e_resp;
        write_single(64'h0, {SW{8'h3C}}, {SW{1'b1}}, resp);
        checks++; if (resp !== 2'd0) begin failures++; $display("FAIL oor_base_write: resp %0d exp 0", resp); end
`ifdef VX_AXI_MEM_OOR_SLVERR_EN
        write_single(64'h4000, {DW{1'b0}}, {SW{1'b1}}, resp);
        checks++; if (resp !== 2'd2) begin failures++; $display("FAIL oor_write_resp: resp %0d exp 2", resp); end
        e_data = '0;
        e_resp = 2'd2;
`else
        e_data = {SW{8'h3C}};
        e_resp = 2'd0;
`endif
        do_read(64'h4000, 8'd0, 32'd4, 1'b0);
        checks++;
        if (got_data_q.size() != 1 || got_data_q[0] !== e_data || got_resp_q[0] !== e_resp) begin
            failures++; $display("FAIL oor_read: beats %0d data %0h resp %0d exp 1 %0h %0d", got_data_q.size(),
                                 got_data_q.size() ? got_data_q[0] : '0, got_data_q.size() ? got_resp_q[0] : 2'd0, e_data, e_resp);
        end
        do_read(64'h0, 8'd0, 32'd4, 1'b0);
        checks++;
        if (got_data_q.size() != 1 || got_data_q[0] !== {SW{8'h3C}}) begin
            failures++; $display("FAIL oor_base_intact: data %0h exp %0h", got_data_q.size() ? got_data_q[0] : '0, {SW{8'h3C}});
        end
    endtask

    task automatic test_reset_mid_read();
        int n = 0;
        rready = 1'b0;
        do_ar(64'h400, 8'd7, 32'd3);
        while (!rvalid && n < 10) begin @(posedge clk); #1; n++; end
        checks++; if (rvalid !== 1'b1) begin failures++; $display("FAIL mid_read_started: rvalid %b exp 1", rvalid); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL mid_read_async_drop: rvalid %b exp 0", rvalid); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (arready !== 1'b1 || rvalid !== 1'b0) begin
            failures++; $display("FAIL mid_read_recover: arready %b rvalid %b exp 1 0", arready, rvalid);
        end
        do_read(64'h400, 8'd1, 32'd3, 1'b0);
        checks++; if (got_data_q.size() != 2 || extra_beats != 0) begin
            failures++; $display("FAIL mid_read_new_count: got %0d extra %0d exp 2 0", got_data_q.size(), extra_beats);
        end
        for (int i = 0; i < got_data_q.size(); i++) begin
            checks++;
            if (got_data_q[i] !== burst_word(i) || got_last_q[i] !== (i == 1) || got_id_q[i] !== 32'd3) begin
                failures++; $display("FAIL mid_read_new_beat%0d: data %0h last %b id %0d exp %0h %b 3",
                                     i, got_data_q[i], got_last_q[i], got_id_q[i], burst_word(i), i == 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_readback();
        test_burst_backpressure();
        test_partial_strobe();
        test_wlast_early();
        test_out_of_range();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
